demux1to2_64_pkt: RTL and testbench
===================================

Name: demux1to2_64_pkt

Overview:
- Packet-granular 1-to-2 demultiplexer for the 64-bit word stream in the cpu-fifo datapath; the splitting counterpart to the 2:1 64-bit select path that merges two sources.
- Takes one valid/ready stream with SOP/EOP framing and steers each whole packet to output port 0 or 1.
- The port is chosen by `sel`, sampled on the SOP word.
- Each output has a one-deep registered stage; the block also keeps per-port packet counters and a framing-error drop counter.

Parameters:
- DATA_WIDTH, 64, width of data words on all ports.
- CNT_WIDTH, 16, width of each statistics counter; counters wrap modulo 2^CNT_WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  1  destination for the packet whose SOP word is accepted this cycle; 0 = port 0, 1 = port 1.
- in_data  input  DATA_WIDTH  input word.
- in_sop  input  1  first word of packet.
- in_eop  input  1  last word of packet.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the word this cycle; combinational.
- out0_data  output  DATA_WIDTH  port 0 word; registered.
- out0_sop, out0_eop  output  1 each  port 0 framing; registered.
- out0_valid  output  1  port 0 word present.
- out0_ready  input  1  port 0 sink accepts.
- out1_data, out1_sop, out1_eop, out1_valid  output  DATA_WIDTH/1/1/1  port 1, same as port 0.
- out1_ready  input  1  port 1 sink accepts.
- pkt_cnt0  output  CNT_WIDTH  packets (EOP words) delivered to port 0.
- pkt_cnt1  output  CNT_WIDTH  packets (EOP words) delivered to port 1.
- drop_cnt  output  CNT_WIDTH  words discarded for bad framing.
- busy  output  1  high while mid-packet (state != IDLE).

Behaviour:
- Reset (synchronous, overrides everything):
  - state = IDLE.
  - out0_valid, out1_valid, all sop/eop = 0; out*_data = 0.
  - All counters = 0; busy = 0.
  - Reset mid-packet truncates the packet. Its remaining words arriving after reset are non-SOP in IDLE and are dropped.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Output stage k can load when `room_k = !outk_valid || outk_ready`.
  - out*_data/sop/eop stay stable while outk_valid && !outk_ready.
  - Latency is 1 cycle from input acceptance to outk_valid.
- FSM states: IDLE, ROUTE0, ROUTE1.
  - IDLE, in_valid && in_sop:
    - target = sel; in_ready = room_sel.
    - On transfer, load the target stage.
    - If in_eop is also set (single-word packet), stay in IDLE; otherwise go to ROUTE<sel>.
  - IDLE, in_valid && !in_sop:
    - in_ready = 1; word discarded; drop_cnt += 1.
  - ROUTEk:
    - in_ready = room_k; `sel` is ignored.
    - Words with !in_sop load stage k.
    - A word with in_eop loads stage k and returns to IDLE.
  - ROUTEk, in_sop seen (missing EOP):
    - in_ready = room_k; the word is forwarded to stage k with out_eop forced to 1 and out_sop = 0. This closes the broken packet.
    - drop_cnt += 1; state returns to IDLE.
    - The upstream source's next packet begins fresh.
- Counters:
  - pkt_cntk increments when stage k loads a word with eop = 1, including forced EOP.
  - drop_cnt increments as specified above.
  - All counters wrap.
- Simultaneous events:
  - An output stage may drain and reload on the same edge (room_k = 1 through outk_ready), so back-to-back words run at full rate.
  - The idle port's stage keeps draining independently.
  - A packet switch is allowed on the cycle after EOP acceptance, with no bubble.
- in_ready never depends on in_valid, which prevents combinational loops upstream.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ROUTE0=2'd1, ROUTE1=2'd2) and the DATA_WIDTH/CNT_WIDTH defaults.
- One sub-module, `pkt_out_stage_64`: a one-deep valid/ready register holding {data, sop, eop}. It has inputs load, din and ready, and outputs valid, dout and room. It is instantiated twice.
- FSM and counters live in the top level.

Test Plan:
- Back-to-back routing, sinks always ready:
  - Stimulus: 3-word packet (data 0x11, 0x22, 0x33) with sel=0, then a 2-word packet (0xA0, 0xA1) with sel=1.
  - Required: port 0 shows 0x11/0x22/0x33 (sop on the first, eop on the last), each 1 cycle after acceptance.
  - Required: port 1 shows 0xA0/0xA1 starting the cycle after 0x33 is accepted.
  - Required: pkt_cnt0 = 1, pkt_cnt1 = 1.
- Backpressure:
  - Stimulus: out0_ready = 0 for 4 cycles during a 4-word sel=0 packet.
  - Required: in_ready = 0 after the first word loads; out0_data holds stable.
  - Required: on release, all 4 words arrive in order with no loss or duplication, and port 1 is untouched.
- Single-word packet:
  - Stimulus: in_sop = in_eop = 1, data 0xDEAD, sel=1.
  - Required: out1 shows 0xDEAD with sop = eop = 1; state stays IDLE; pkt_cnt1 = 1.
- Framing errors:
  - Stimulus: a non-SOP word in IDLE.
  - Required: in_ready = 1, word dropped, drop_cnt = 1.
  - Stimulus: SOP arriving mid-packet in ROUTE0.
  - Required: that word appears on out0 with eop forced to 1; drop_cnt = 2; pkt_cnt0 increments; state returns to IDLE.
- Reset mid-packet:
  - Stimulus: assert reset after word 2 of a 5-word packet.
  - Required: next cycle all out*_valid = 0 and counters = 0.
  - Required: the remaining 3 words are dropped (drop_cnt = 3); a following SOP routes normally.

Source files
------------

// File: rtl/demux1to2_64_pkt_pkg.sv
// Shared state encodings and width defaults for the packet-granular 1:2 demultiplexer.
package demux1to2_64_pkt_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUTE0 = 2'd1,
      ROUTE1 = 2'd2
   } state_t;

   function automatic state_t route_state(input logic port);
      return port ? ROUTE1 : ROUTE0;
   endfunction

endpackage

// File: rtl/demux1to2_64_pkt_if.sv
// Valid/ready word stream with SOP/EOP framing, used for the input and both outputs.
interface demux1to2_64_pkt_if #(
   parameter int DATA_WIDTH = demux1to2_64_pkt_pkg::DEF_DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] data;
   logic                  sop;
   logic                  eop;
   logic                  valid;
   logic                  ready;

   modport master (
      output data,
      output sop,
      output eop,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  sop,
      input  eop,
      input  valid,
      output ready
   );

endinterface

// File: rtl/demux1to2_64_pkt_out_stage.sv
// One-deep valid/ready output register holding a {data, sop, eop} word.
module pkt_out_stage_64 #(
   parameter int WIDTH = 66
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output logic             room
);

   // Room exists when empty or when the current word leaves on this edge.
   assign room = !valid || ready;

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux1to2_64_pkt.sv
// Steers whole SOP/EOP-framed packets to one of two registered output ports,
// chosen by sel on the SOP word, with per-port packet and framing-drop counters.
module demux1to2_64_pkt
   import demux1to2_64_pkt_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   demux1to2_64_pkt_if.slave     in_port,
   demux1to2_64_pkt_if.master    out0,
   demux1to2_64_pkt_if.master    out1,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  busy
);

   localparam int WORD_W = DATA_WIDTH + 2;

   state_t              state;
   state_t              state_nxt;
   logic                room0;
   logic                room1;
   logic                load0;
   logic                load1;
   logic                valid0;
   logic                valid1;
   logic                in_ready;
   logic                drop_inc;
   logic                route_port;
   logic [WORD_W-1:0]   word;
   logic [WORD_W-1:0]   dout0;
   logic [WORD_W-1:0]   dout1;

   assign route_port = (state == ROUTE1);

   // NOTE: every signal gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load0     = 1'b0;
      load1     = 1'b0;
      drop_inc  = 1'b0;
      word      = {in_port.data, in_port.sop, in_port.eop};

      if (!reset) begin
         case (state)
            IDLE: begin
               if (in_port.sop) begin
                  in_ready = sel ? room1 : room0;
                  if (in_port.valid && in_ready) begin
                     load0 = !sel;
                     load1 = sel;
                     if (!in_port.eop) state_nxt = route_state(sel);
                  end
               end else begin
                  in_ready = 1'b1;
                  drop_inc = in_port.valid;
               end
            end
            ROUTE0, ROUTE1: begin
               in_ready = route_port ? room1 : room0;
               if (in_port.valid && in_ready) begin
                  load0 = !route_port;
                  load1 = route_port;
                  if (in_port.sop) begin
                     // A new SOP closes the broken packet: forward it as its last word.
                     word      = {in_port.data, 2'b01};
                     drop_inc  = 1'b1;
                     state_nxt = IDLE;
                  end else if (in_port.eop) begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
         drop_cnt <= '0;
      end else begin
         if (load0 && word[0]) pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
         if (load1 && word[0]) pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
         if (drop_inc)         drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
   end

   pkt_out_stage_64 #(.WIDTH(WORD_W)) u_stage0 (
      .clk   (clk),
      .reset (reset),
      .load  (load0),
      .din   (word),
      .ready (out0.ready),
      .valid (valid0),
      .dout  (dout0),
      .room  (room0)
   );

   pkt_out_stage_64 #(.WIDTH(WORD_W)) u_stage1 (
      .clk   (clk),
      .reset (reset),
      .load  (load1),
      .din   (word),
      .ready (out1.ready),
      .valid (valid1),
      .dout  (dout1),
      .room  (room1)
   );

   assign in_port.ready = in_ready;

   assign out0.data  = dout0[WORD_W-1:2];
   assign out0.sop   = dout0[1];
   assign out0.eop   = dout0[0];
   assign out0.valid = valid0;

   assign out1.data  = dout1[WORD_W-1:2];
   assign out1.sop   = dout1[1];
   assign out1.eop   = dout1[0];
   assign out1.valid = valid1;

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_demux1to2_64_pkt.sv
// Directed self-checking bench for demux1to2_64_pkt: routing, backpressure,
// single-word packets, framing errors and reset mid-packet.
`timescale 1ns/1ps
module tb_demux1to2_64_pkt;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [15:0] pkt_cnt0;
   logic [15:0] pkt_cnt1;
   logic [15:0] drop_cnt;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      int          cyc;
   } obs_t;

   obs_t q0[$];
   obs_t q1[$];

   demux1to2_64_pkt_if #(.DATA_WIDTH(64)) in_if ();
   demux1to2_64_pkt_if #(.DATA_WIDTH(64)) o0_if ();
   demux1to2_64_pkt_if #(.DATA_WIDTH(64)) o1_if ();

   demux1to2_64_pkt #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .sel      (sel),
      .in_port  (in_if),
      .out0     (o0_if),
      .out1     (o1_if),
      .pkt_cnt0 (pkt_cnt0),
      .pkt_cnt1 (pkt_cnt1),
      .drop_cnt (drop_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output transfers are logged mid-cycle; inputs only change just after rising edges.
   always @(negedge clk) begin
      if (o0_if.valid === 1'b1 && o0_if.ready === 1'b1)
         q0.push_back(obs_t'{o0_if.data, o0_if.sop, o0_if.eop, cyc});
      if (o1_if.valid === 1'b1 && o1_if.ready === 1'b1)
         q1.push_back(obs_t'{o1_if.data, o1_if.sop, o1_if.eop, cyc});
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      sel         = 1'b0;
      in_if.data  = '0;
      idle();
      o0_if.ready = 1'b1;
      o1_if.ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   // Drives one word and returns the cycle stamp of the edge that accepted it.
   task automatic send_word(input logic s, input logic [63:0] d, input logic sp,
                            input logic ep, output int acc);
      int waited;
      waited      = 0;
      sel         = s;
      in_if.data  = d;
      in_if.sop   = sp;
      in_if.eop   = ep;
      in_if.valid = 1'b1;
      acc         = -1;
      while (acc < 0) begin
         @(negedge clk);
         if (in_if.ready === 1'b1) begin
            @(posedge clk);
            #1;
            acc = cyc;
         end else begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 50) begin
               checks++;
               failures++;
               $display("FAIL send_timeout data=%h in_ready stayed %b, required 1 within 50 cycles",
                        d, in_if.ready);
               acc = cyc;
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (o0_if.valid !== 1'b0 || o1_if.valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got out0_valid=%b out1_valid=%b expected 0/0",
                  o0_if.valid, o1_if.valid);
      end
      checks++;
      if (o0_if.data !== 64'h0 || o1_if.data !== 64'h0 || o0_if.sop !== 1'b0 ||
          o0_if.eop !== 1'b0 || o1_if.sop !== 1'b0 || o1_if.eop !== 1'b0) begin
         failures++;
         $display("FAIL reset_data got d0=%h d1=%h sop/eop=%b%b%b%b expected all 0",
                  o0_if.data, o1_if.data, o0_if.sop, o0_if.eop, o1_if.sop, o1_if.eop);
      end
      checks++;
      if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_counters got cnt0=%0d cnt1=%0d drop=%0d busy=%b expected 0/0/0/0",
                  pkt_cnt0, pkt_cnt1, drop_cnt, busy);
      end
   endtask

   task automatic test_back_to_back();
      int          a[5];
      logic [63:0] e0[3] = '{64'h11, 64'h22, 64'h33};
      logic [63:0] e1[2] = '{64'hA0, 64'hA1};
      do_reset();
      send_word(1'b0, 64'h11, 1'b1, 1'b0, a[0]);
      send_word(1'b0, 64'h22, 1'b0, 1'b0, a[1]);
      send_word(1'b0, 64'h33, 1'b0, 1'b1, a[2]);
      send_word(1'b1, 64'hA0, 1'b1, 1'b0, a[3]);
      send_word(1'b1, 64'hA1, 1'b0, 1'b1, a[4]);
      idle();
      wait_cycles(3);

      checks++;
      if (a[3] !== a[2] + 1) begin
         failures++;
         $display("FAIL b2b_switch_bubble A0 accepted at %0d expected %0d", a[3], a[2] + 1);
      end
      checks++;
      if (q0.size() != 3) begin
         failures++;
         $display("FAIL b2b_port0_count got %0d words expected 3", q0.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (q0[i].data !== e0[i] || q0[i].sop !== (i == 0) || q0[i].eop !== (i == 2) ||
                q0[i].cyc !== a[i]) begin
               failures++;
               $display("FAIL b2b_port0_word%0d got %h sop=%b eop=%b cyc=%0d expected %h sop=%b eop=%b cyc=%0d",
                        i, q0[i].data, q0[i].sop, q0[i].eop, q0[i].cyc,
                        e0[i], (i == 0), (i == 2), a[i]);
            end
         end
      end
      checks++;
      if (q1.size() != 2) begin
         failures++;
         $display("FAIL b2b_port1_count got %0d words expected 2", q1.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (q1[i].data !== e1[i] || q1[i].sop !== (i == 0) || q1[i].eop !== (i == 1) ||
                q1[i].cyc !== a[3 + i]) begin
               failures++;
               $display("FAIL b2b_port1_word%0d got %h sop=%b eop=%b cyc=%0d expected %h sop=%b eop=%b cyc=%0d",
                        i, q1[i].data, q1[i].sop, q1[i].eop, q1[i].cyc,
                        e1[i], (i == 0), (i == 1), a[3 + i]);
            end
         end
      end
      checks++;
      if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
         failures++;
         $display("FAIL b2b_pkt_cnt got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1);
      end
   endtask

   task automatic test_backpressure();
      int acc;
      do_reset();
      o0_if.ready = 1'b0;
      send_word(1'b0, 64'h100, 1'b1, 1'b0, acc);
      in_if.data = 64'h101;
      in_if.sop  = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (in_if.ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready got %b expected 0", in_if.ready);
         end
         checks++;
         if (o0_if.valid !== 1'b1 || o0_if.data !== 64'h100 || o0_if.sop !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got valid=%b data=%h sop=%b expected 1/100/1",
                     o0_if.valid, o0_if.data, o0_if.sop);
         end
         @(posedge clk);
         #1;
      end
      o0_if.ready = 1'b1;
      send_word(1'b0, 64'h101, 1'b0, 1'b0, acc);
      send_word(1'b0, 64'h102, 1'b0, 1'b0, acc);
      send_word(1'b0, 64'h103, 1'b0, 1'b1, acc);
      idle();
      wait_cycles(3);

      checks++;
      if (q0.size() != 4) begin
         failures++;
         $display("FAIL bp_port0_count got %0d words expected 4", q0.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (q0[i].data !== 64'h100 + 64'(i) || q0[i].sop !== (i == 0) || q0[i].eop !== (i == 3)) begin
               failures++;
               $display("FAIL bp_port0_word%0d got %h sop=%b eop=%b expected %h sop=%b eop=%b",
                        i, q0[i].data, q0[i].sop, q0[i].eop, 64'h100 + 64'(i), (i == 0), (i == 3));
            end
         end
      end
      checks++;
      if (q1.size() != 0 || pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
         failures++;
         $display("FAIL bp_side_effects got port1_words=%0d cnt0=%0d cnt1=%0d expected 0/1/0",
                  q1.size(), pkt_cnt0, pkt_cnt1);
      end
   endtask

   task automatic test_single_word();
      int acc;
      do_reset();
      send_word(1'b1, 64'hDEAD, 1'b1, 1'b1, acc);
      idle();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_busy got %b expected 0", busy);
      end
      wait_cycles(3);
      checks++;
      if (q1.size() != 1) begin
         failures++;
         $display("FAIL single_port1_count got %0d words expected 1", q1.size());
      end else begin
         checks++;
         if (q1[0].data !== 64'hDEAD || q1[0].sop !== 1'b1 || q1[0].eop !== 1'b1 || q1[0].cyc !== acc) begin
            failures++;
            $display("FAIL single_word got %h sop=%b eop=%b cyc=%0d expected dead sop=1 eop=1 cyc=%0d",
                     q1[0].data, q1[0].sop, q1[0].eop, q1[0].cyc, acc);
         end
      end
      checks++;
      if (q0.size() != 0 || pkt_cnt1 !== 16'd1 || pkt_cnt0 !== 16'd0) begin
         failures++;
         $display("FAIL single_counts got port0_words=%0d cnt0=%0d cnt1=%0d expected 0/0/1",
                  q0.size(), pkt_cnt0, pkt_cnt1);
      end
   endtask

   task automatic test_framing();
      int acc;
      do_reset();
      sel         = 1'b0;
      in_if.data  = 64'h55;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      in_if.valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_if.ready !== 1'b1) begin
         failures++;
         $display("FAIL frame_idle_ready got %b expected 1", in_if.ready);
      end
      @(posedge clk);
      #1;
      idle();
      wait_cycles(3);
      checks++;
      if (q0.size() != 0 || q1.size() != 0 || drop_cnt !== 16'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL frame_idle_drop got words=%0d/%0d drop=%0d busy=%b expected 0/0/1/0",
                  q0.size(), q1.size(), drop_cnt, busy);
      end

      send_word(1'b0, 64'h60, 1'b1, 1'b0, acc);
      send_word(1'b0, 64'h61, 1'b0, 1'b0, acc);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL frame_mid_busy got %b expected 1", busy);
      end
      send_word(1'b1, 64'h70, 1'b1, 1'b0, acc);
      idle();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL frame_forced_idle busy got %b expected 0", busy);
      end
      wait_cycles(3);
      checks++;
      if (q0.size() != 3 || q1.size() != 0) begin
         failures++;
         $display("FAIL frame_counts got port0=%0d port1=%0d words expected 3/0", q0.size(), q1.size());
      end else begin
         checks++;
         if (q0[0].data !== 64'h60 || q0[0].sop !== 1'b1 || q0[0].eop !== 1'b0 ||
             q0[1].data !== 64'h61 || q0[1].sop !== 1'b0 || q0[1].eop !== 1'b0) begin
            failures++;
            $display("FAIL frame_head got %h/%b%b %h/%b%b expected 60/10 61/00",
                     q0[0].data, q0[0].sop, q0[0].eop, q0[1].data, q0[1].sop, q0[1].eop);
         end
         checks++;
         if (q0[2].data !== 64'h70 || q0[2].sop !== 1'b0 || q0[2].eop !== 1'b1) begin
            failures++;
            $display("FAIL frame_forced_eop got %h sop=%b eop=%b expected 70 sop=0 eop=1",
                     q0[2].data, q0[2].sop, q0[2].eop);
         end
      end
      checks++;
      if (drop_cnt !== 16'd2 || pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
         failures++;
         $display("FAIL frame_counters got drop=%0d cnt0=%0d cnt1=%0d expected 2/1/0",
                  drop_cnt, pkt_cnt0, pkt_cnt1);
      end

      send_word(1'b1, 64'h80, 1'b1, 1'b1, acc);
      idle();
      wait_cycles(3);
      checks++;
      if (q1.size() != 1 || pkt_cnt1 !== 16'd1 || drop_cnt !== 16'd2) begin
         failures++;
         $display("FAIL frame_recover got port1=%0d cnt1=%0d drop=%0d expected 1/1/2",
                  q1.size(), pkt_cnt1, drop_cnt);
      end else begin
         checks++;
         if (q1[0].data !== 64'h80) begin
            failures++;
            $display("FAIL frame_recover_data got %h expected 80", q1[0].data);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      int acc;
      do_reset();
      send_word(1'b0, 64'h1FF, 1'b0, 1'b0, acc);
      send_word(1'b1, 64'h210, 1'b1, 1'b1, acc);
      send_word(1'b0, 64'h200, 1'b1, 1'b0, acc);
      send_word(1'b0, 64'h201, 1'b0, 1'b0, acc);
      idle();
      o0_if.ready = 1'b0;
      reset       = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (o0_if.valid !== 1'b0 || o1_if.valid !== 1'b0 || o0_if.data !== 64'h0) begin
         failures++;
         $display("FAIL rst_mid_outputs got v0=%b v1=%b d0=%h expected 0/0/0",
                  o0_if.valid, o1_if.valid, o0_if.data);
      end
      checks++;
      if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_counters got cnt0=%0d cnt1=%0d drop=%0d busy=%b expected 0/0/0/0",
                  pkt_cnt0, pkt_cnt1, drop_cnt, busy);
      end
      o0_if.ready = 1'b1;
      q0.delete();
      q1.delete();
      send_word(1'b0, 64'h202, 1'b0, 1'b0, acc);
      send_word(1'b0, 64'h203, 1'b0, 1'b0, acc);
      send_word(1'b0, 64'h204, 1'b0, 1'b1, acc);
      idle();
      wait_cycles(3);
      checks++;
      if (drop_cnt !== 16'd3 || q0.size() != 0 || q1.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_tail_drop got drop=%0d words=%0d/%0d busy=%b expected 3/0/0/0",
                  drop_cnt, q0.size(), q1.size(), busy);
      end
      send_word(1'b0, 64'h300, 1'b1, 1'b1, acc);
      idle();
      wait_cycles(3);
      checks++;
      if (q0.size() != 1 || pkt_cnt0 !== 16'd1) begin
         failures++;
         $display("FAIL rst_mid_next_pkt got port0=%0d cnt0=%0d expected 1/1", q0.size(), pkt_cnt0);
      end else begin
         checks++;
         if (q0[0].data !== 64'h300 || q0[0].sop !== 1'b1 || q0[0].eop !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_next_word got %h sop=%b eop=%b expected 300 sop=1 eop=1",
                     q0[0].data, q0[0].sop, q0[0].eop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_single_word();
      test_framing();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
